// File: rtl/lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// lcd_bus_receiver
//
// Receiver/display model for the character-LCD parallel bus. Each falling
// edge of lcd_en is a strobe: with rs=1 the byte is written into the
// character buffer at the cursor, with rs=0 it is taken as a command
// (set address, clear, or captured-only). A rising edge of lcd_rst homes the
// cursor. The clear command sweeps CLEAR_CHAR through every cell, one cell
// per cycle, while busy is high. A registered read port exposes the buffer.
//
// Optional feature macro: LCD_RX_STATS_EN
//   When defined, adds wr_count / cmd_count outputs: saturating 16-bit
//   counts of accepted data writes and accepted commands.
// ---------------------------------------------------------------------------
module lcd_bus_receiver #(
    parameter int         DEPTH      = 64,
    parameter int         ADDR_W     = 6,
    parameter logic [7:0] CLEAR_CHAR = 8'h5F
) (
    input  logic              system_clk,
    input  logic              rst,
    input  logic              lcd_en,
    input  logic              lcd_rs,
    input  logic              lcd_rw,
    input  logic              lcd_rst,
    input  logic [7:0]        lcd_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              cmd_valid,
    output logic [7:0]        cmd_byte,
    output logic              page_start,
    output logic              err_busy
`ifdef LCD_RX_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       cmd_count
`endif
);

    localparam logic [7:0]        CMD_CLEAR = 8'h01;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;

    // Edge-detect history of the bus control lines
    logic en_q;
    logic rst_q;

    logic strobe;
    logic home;
    logic idle;
    logic wr_acc;
    logic cmd_acc;
    logic [ADDR_W-1:0] wr_addr;

    // Character buffer and its single write port
    logic [7:0]        mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

`ifdef LCD_RX_STATS_EN
    // Saturating increment for the statistics counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end
        return val + 16'd1;
    endfunction
`endif

    // Strobe and home event decode; bus values are sampled in the strobe cycle
    assign strobe  = en_q & ~lcd_en;
    assign home    = ~rst_q & lcd_rst;
    assign idle    = (state == ST_IDLE);
    assign wr_acc  = strobe & ~lcd_rw &  lcd_rs & idle;
    assign cmd_acc = strobe & ~lcd_rw & ~lcd_rs & idle;

    // A home coinciding with a data strobe steers the write to cell 0
    assign wr_addr = home ? '0 : cursor;

    assign busy = (state == ST_CLEAR);

    // Register lcd_en and lcd_rst so their edges can be detected
    always_ff @(posedge system_clk) begin
        if (rst) begin
            en_q  <= 1'b0;
            rst_q <= 1'b0;
        end else begin
            en_q  <= lcd_en;
            rst_q <= lcd_rst;
        end
    end

    // Select the buffer write source: clear sweep has priority over bus writes
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = lcd_data;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = CLEAR_CHAR;
            end else if (wr_acc) begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr;
                mem_wdata = lcd_data;
            end
        end
    end

    // Buffer storage; contents intentionally survive rst
    always_ff @(posedge system_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge system_clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // Control FSM: strobe handling in IDLE, cell-by-cell sweep in CLEAR
    always_ff @(posedge system_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            cursor     <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            page_start <= 1'b0;
            err_busy   <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            page_start <= home;
            unique case (state)
                ST_IDLE: begin
                    if (wr_acc) begin
                        // Cursor wraps naturally at the ADDR_W boundary
                        cursor <= wr_addr + ADDR_W'(1);
                    end else if (cmd_acc) begin
                        cmd_byte  <= lcd_data;
                        cmd_valid <= 1'b1;
                        if (lcd_data[7]) begin
                            // Explicit set-address wins over a coincident home
                            cursor <= lcd_data[ADDR_W-1:0];
                        end else begin
                            if (home) begin
                                cursor <= '0;
                            end
                            if (lcd_data == CMD_CLEAR) begin
                                state   <= ST_CLEAR;
                                clr_cnt <= '0;
                            end
                        end
                    end else if (home) begin
                        // Covers no strobe as well as ignored rw=1 strobes
                        cursor <= '0;
                    end
                end
                ST_CLEAR: begin
                    // Any strobe during the sweep is dropped and flagged
                    if (strobe) begin
                        err_busy <= 1'b1;
                    end
                    if (home) begin
                        cursor <= '0;
                    end
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST_CELL) begin
                        state  <= ST_IDLE;
                        cursor <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LCD_RX_STATS_EN
    // Count accepted data writes and accepted commands, saturating
    always_ff @(posedge system_clk) begin
        if (rst) begin
            wr_count  <= '0;
            cmd_count <= '0;
        end else begin
            if (wr_acc) begin
                wr_count <= sat_inc16(wr_count);
            end
            if (cmd_acc) begin
                cmd_count <= sat_inc16(cmd_count);
            end
        end
    end
`endif

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Receiver/display model for the character-LCD parallel bus (RS, RW, EN, RST, DATA[7:0]) driven by the LCD driver.
- Decodes each EN falling-edge strobe into a data write (into a character buffer at the cursor) or a command.
- Exposes a registered read port so display contents can be checked in simulation or mirrored onto other outputs (7-seg, UART dump) on the board.

Parameters:
- DEPTH, 64, number of character cells (page 0 = 0..31, page 1 = 32..63).
- ADDR_W, 6, cursor/read address width; DEPTH = 2**ADDR_W.
- CLEAR_CHAR, 8'h5F, code written to every cell by the clear command (blank glyph in the team font table).

Ports:
- system_clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- lcd_en  in  1  bus enable; a strobe is a 1->0 transition.
- lcd_rs  in  1  1 = data, 0 = command.
- lcd_rw  in  1  1 = read cycle (ignored), 0 = write.
- lcd_rst  in  1  page-start marker; a rising edge homes the cursor.
- lcd_data  in  8  bus data.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency.
- cursor  out  ADDR_W  next write address.
- busy  out  1  clear sequence in progress.
- cmd_valid  out  1  1-cycle pulse on an accepted command strobe.
- cmd_byte  out  8  last accepted command byte.
- page_start  out  1  1-cycle pulse on a lcd_rst rising edge.
- err_busy  out  1  sticky; a strobe arrived while busy.

Behaviour:
- Reset values: rd_data=0, cursor=0, busy=0, cmd_valid=0, cmd_byte=0, page_start=0, err_busy=0.
  - Internal en_q=0 and rst_q=0.
  - The buffer RAM is not cleared by rst.
- Edge detect: en_q and rst_q register lcd_en and lcd_rst every cycle.
  - strobe = en_q & ~lcd_en.
  - home = ~rst_q & lcd_rst.
  - Bus values (rs, rw, data) are sampled in the strobe cycle itself; the driver holds them stable across the EN fall.
- Write path: strobe with rw=0 and rs=1 (and not busy):
  - buffer[cursor] <= data.
  - cursor <= cursor+1, wrapping modulo DEPTH (63 -> 0).
- Command path: strobe with rw=0 and rs=0 (and not busy):
  - cmd_byte <= data; cmd_valid=1 for one cycle.
  - data[7]=1: cursor <= data[ADDR_W-1:0] (set address).
  - data==8'h01: enter CLEAR.
  - All other commands: captured only, no effect.
- rw=1 strobe: ignored entirely, with no cursor change and no pulse.
- Home: page_start=1 for one cycle and cursor <= 0.
  - If home and a data strobe occur in the same cycle, the write lands at address 0 and cursor becomes 1.
- FSM with two states:
  - IDLE: accepts strobes.
  - CLEAR: busy=1; writes CLEAR_CHAR to one cell per cycle, from address 0 up to DEPTH-1, using an internal counter.
  - After writing cell DEPTH-1: cursor <= 0, busy=0, return to IDLE.
  - Total duration is DEPTH cycles, starting the cycle after the command strobe.
- Busy handling: any strobe while busy is dropped, sets err_busy=1, and does not pulse cmd_valid.
  - A home event while busy still pulses page_start, but the cursor is forced to 0 at the end of CLEAR anyway.
- Read port: rd_data <= buffer[rd_addr] every cycle.
  - Reading the address written in cycle N returns the new value if rd_addr is presented at N+1 (data at N+2).
- Reset mid-CLEAR: returns to IDLE immediately; the buffer is left partially cleared.

Optional Feature:
- Macro: LCD_RX_STATS_EN.
- Defined: adds outputs wr_count[15:0] and cmd_count[15:0].
  - wr_count increments on each accepted data write; cmd_count on each accepted command.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports do not exist and no counter logic is generated.

Test Plan:
1. Reset, then 6 data strobes 8'h33,8'h43,8'h4F,8'h52,8'h45,8'h1A -> buffer[0..5] equals those bytes; cursor=6.
2. Command 8'hA0 then data 8'h31 -> cmd_valid pulses once, cmd_byte=8'hA0, buffer[32]=8'h31, cursor=33.
3. Cursor at 63, two data strobes 8'h41,8'h42 -> buffer[63]=8'h41, buffer[0]=8'h42, cursor=1.
4. Command 8'h01 -> busy high exactly 64 cycles; every cell reads 8'h5F; cursor=0.
   - A data strobe mid-clear sets err_busy=1, and that byte is absent afterwards.
5. lcd_rst 0->1 with cursor=20, followed by a data strobe 8'h35 -> page_start pulses, buffer[0]=8'h35, cursor=1.
   - An rw=1 strobe leaves cursor and buffer unchanged.
6. rst asserted during CLEAR at count 10 -> busy=0 and cursor=0 next cycle; cells 0..9 (or up to the last written cell) read 8'h5F and higher cells keep their old data.
   - With LCD_RX_STATS_EN defined, wr_count/cmd_count match the accepted strobes in scenarios 1-5.
